// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder sequencer: drives one external 4-bit adder a nibble per clock, LSB first.
// Optional SUB_MODE_EN macro adds an i_sub port for two's-complement subtraction.
module nibble_serial_adder_ctrl #(
  parameter int NUM_NIBBLES = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [4*NUM_NIBBLES-1:0] i_op_a,
  input  logic [4*NUM_NIBBLES-1:0] i_op_b,
  input  logic                     i_cin,
`ifdef SUB_MODE_EN
  input  logic                     i_sub,
`endif
  output logic                     o_busy,
  output logic                     o_done,
  output logic [4*NUM_NIBBLES-1:0] o_result,
  output logic                     o_cout,
  output logic [3:0]               o_add_in1,
  output logic [3:0]               o_add_in2,
  output logic                     o_add_carry_in,
  input  logic [3:0]               i_add_sum,
  input  logic                     i_add_carry_out
);

  localparam int W  = 4 * NUM_NIBBLES;
  localparam int IW = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [W-1:0]  r_opA;
  logic [W-1:0]  r_opB;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_result;
  logic          r_cout;
  logic [W-1:0]  w_opBIn;
  logic          w_cinIn;
  logic          w_lastNibble;

  // Subtraction is A + ~B + 1, so only operand B and the seed carry change.
`ifdef SUB_MODE_EN
  assign w_opBIn = i_sub ? ~i_op_b : i_op_b;
  assign w_cinIn = i_sub ? 1'b1 : i_cin;
`else
  assign w_opBIn = i_op_b;
  assign w_cinIn = i_cin;
`endif

  assign w_lastNibble = (r_idx == LAST_IDX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState    = r_state;
    o_add_in1      = 4'h0;
    o_add_in2      = 4'h0;
    o_add_carry_in = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        o_add_in1      = r_opA[{r_idx, 2'b00} +: 4];
        o_add_in2      = r_opB[{r_idx, 2'b00} +: 4];
        o_add_carry_in = r_carry;
        if (w_lastNibble) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Operands are frozen at accept; the adder result is folded back one slice per edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_opA    <= '0;
      r_opB    <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_opA   <= i_op_a;
            r_opB   <= w_opBIn;
            r_carry <= w_cinIn;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_result[{r_idx, 2'b00} +: 4] <= i_add_sum;
          r_carry                       <= i_add_carry_out;
          r_idx                         <= r_idx + 1'b1;
          if (w_lastNibble) begin
            r_cout <= i_add_carry_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy   = (r_state != IDLE);
  assign o_done   = (r_state == DONE);
  assign o_result = r_result;
  assign o_cout   = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl with a behavioural 4-bit adder attached.
// Subtraction vectors are compiled in only when SUB_MODE_EN is defined.
module tb_nibble_serial_adder_ctrl;

  localparam int NN = 4;
  localparam int W  = 4 * NN;

  typedef struct {
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         cin;
    logic [W-1:0] expResult;
    logic         expCout;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic [3:0]   addIn1;
  logic [3:0]   addIn2;
  logic         addCarryIn;
  logic [3:0]   addSum;
  logic         addCarryOut;

  int testsRun    = 0;
  int testsFailed = 0;
  logic [3:0] seqIn1 [16];
  logic [3:0] seqIn2 [16];
  logic       seqCin [16];
  vec_t       vectors [8];

  always #5 clk = ~clk;

  assign {addCarryOut, addSum} = 5'(addIn1) + 5'(addIn2) + 5'(addCarryIn);

  nibble_serial_adder_ctrl #(.NUM_NIBBLES(NN)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_op_a         (opA),
    .i_op_b         (opB),
    .i_cin          (cin),
`ifdef SUB_MODE_EN
    .i_sub          (sub),
`endif
    .o_busy         (busy),
    .o_done         (done),
    .o_result       (result),
    .o_cout         (cout),
    .o_add_in1      (addIn1),
    .o_add_in2      (addIn2),
    .o_add_carry_in (addCarryIn),
    .i_add_sum      (addSum),
    .i_add_carry_out(addCarryOut)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issues one operation and waits (bounded) for done, logging the adder drive per RUN cycle.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                               input logic s, output int cycles);
    opA   = a;
    opB   = b;
    cin   = c;
    sub   = s;
    start = 1'b1;
    tick();
    start  = 1'b0;
    cycles = 0;
    while (!done && cycles < 20) begin
      if (cycles < 16) begin
        seqIn1[cycles] = addIn1;
        seqIn2[cycles] = addIn2;
        seqCin[cycles] = addCarryIn;
      end
      tick();
      cycles++;
    end
  endtask

  initial begin
    int cycles;
    int doneCount;
    int doneAt;
    logic [W-1:0] capResult;
    logic         capCout;

    vectors[0] = '{16'h00B3, 16'h0033, 1'b0, 16'h00E6, 1'b0};
    vectors[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vectors[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vectors[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vectors[4] = '{16'h000A, 16'h0006, 1'b0, 16'h0010, 1'b0};
    vectors[5] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
    vectors[6] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
    vectors[7] = '{16'hABCD, 16'h5432, 1'b1, 16'h0000, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    opA   = '0;
    opB   = '0;
    cin   = 1'b0;
    sub   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    checkOutput("reset result", 32'(result), 32'h0);
    checkOutput("reset cout", 32'(cout), 32'h0);
    checkOutput("reset add_in1", 32'(addIn1), 32'h0);
    checkOutput("reset add_in2", 32'(addIn2), 32'h0);
    checkOutput("reset add_carry_in", 32'(addCarryIn), 32'h0);

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vectors[v].opA, vectors[v].opB, vectors[v].cin, 1'b0, cycles);
      checkOutput($sformatf("vec%0d latency", v), 32'(cycles), 32'(NN));
      checkOutput($sformatf("vec%0d result", v), 32'(result), 32'(vectors[v].expResult));
      checkOutput($sformatf("vec%0d cout", v), 32'(cout), 32'(vectors[v].expCout));
      if (v == 0) begin
        checkOutput("vec0 busy in DONE", 32'(busy), 32'h1);
        checkOutput("vec0 add_in1 in DONE", 32'(addIn1), 32'h0);
        checkOutput("vec0 add_in2 in DONE", 32'(addIn2), 32'h0);
        checkOutput("vec0 add_carry_in in DONE", 32'(addCarryIn), 32'h0);
        checkOutput("vec0 add_in1 seq", {16'h0, seqIn1[0], seqIn1[1], seqIn1[2], seqIn1[3]}, 32'h3B00);
        checkOutput("vec0 add_in2 seq", {16'h0, seqIn2[0], seqIn2[1], seqIn2[2], seqIn2[3]}, 32'h3300);
      end
      if (v == 1) begin
        checkOutput("vec1 add_carry_in seq", {28'h0, seqCin[0], seqCin[1], seqCin[2], seqCin[3]}, 32'h7);
      end
      tick();
      checkOutput($sformatf("vec%0d done drops", v), 32'(done), 32'h0);
      checkOutput($sformatf("vec%0d busy drops", v), 32'(busy), 32'h0);
    end

    // The last result must survive several idle cycles.
    tick();
    tick();
    tick();
    checkOutput("result held idle", 32'(result), 32'h0000);
    checkOutput("cout held idle", 32'(cout), 32'h1);

    // Start held high through RUN and DONE with new operands must not disturb or re-trigger.
    opA   = 16'h1234;
    opB   = 16'h1111;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    opA       = 16'hFFFF;
    opB       = 16'hFFFF;
    cin       = 1'b1;
    doneCount = 0;
    doneAt    = 0;
    capResult = '0;
    capCout   = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (done) begin
        doneCount++;
        doneAt    = k;
        capResult = result;
        capCout   = cout;
      end
      if (k == 5) begin
        checkOutput("busy after done (start held)", 32'(busy), 32'h0);
        start = 1'b0;
      end
    end
    checkOutput("start-in-RUN done count", 32'(doneCount), 32'h1);
    checkOutput("start-in-RUN done edge", 32'(doneAt), 32'(NN));
    checkOutput("start-in-RUN result", 32'(capResult), 32'h2345);
    checkOutput("start-in-RUN cout", 32'(capCout), 32'h0);

    // Reset during the second RUN cycle aborts the operation with no done pulse.
    opA   = 16'h1234;
    opB   = 16'h1111;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort busy", 32'(busy), 32'h0);
    checkOutput("abort done", 32'(done), 32'h0);
    checkOutput("abort result", 32'(result), 32'h0);
    checkOutput("abort cout", 32'(cout), 32'h0);
    doneCount = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done) doneCount++;
    end
    checkOutput("abort no done pulse", 32'(doneCount), 32'h0);
    applyStimulus(16'h000A, 16'h0006, 1'b0, 1'b0, cycles);
    checkOutput("post-abort latency", 32'(cycles), 32'(NN));
    checkOutput("post-abort result", 32'(result), 32'h0010);
    tick();

    // Reset and start on the same edge: reset wins.
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("rst+start busy", 32'(busy), 32'h0);
    tick();
    checkOutput("rst+start still idle", 32'(busy), 32'h0);

`ifdef SUB_MODE_EN
    applyStimulus(16'h0010, 16'h0001, 1'b0, 1'b1, cycles);
    checkOutput("sub1 latency", 32'(cycles), 32'(NN));
    checkOutput("sub1 result", 32'(result), 32'h000F);
    checkOutput("sub1 cout", 32'(cout), 32'h1);
    tick();
    applyStimulus(16'h0000, 16'h0001, 1'b0, 1'b1, cycles);
    checkOutput("sub2 result", 32'(result), 32'hFFFF);
    checkOutput("sub2 cout", 32'(cout), 32'h0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
